fetch_prefetch_queue: RTL and testbench

Instruction prefetch unit sitting directly upstream of the CPU decode stage. Fetches word-addressed 32-bit instructions from instruction memory over a single-outstanding req/ack handshake and buffers them with their PCs in a small queue. Presents them to decode over a valid/ready interface. Flushes and restarts on redirect (branch, jump, call, return).

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 55 +++++
 rtl/fetch_prefetch_queue.sv | 126 ++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, opcode map and the fetch-unit state encoding.
package cpu_pkg;

  localparam int INSN_W = 32;

  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_SUB = 6'b000001;
  localparam logic [5:0] OP_AND = 6'b000010;
  localparam logic [5:0] OP_OR  = 6'b000011;
  localparam logic [5:0] OP_LD  = 6'b010000;
  localparam logic [5:0] OP_ST  = 6'b010001;
  localparam logic [5:0] OP_BEQ = 6'b100000;
  localparam logic [5:0] OP_JMP = 6'b100010;
  localparam logic [5:0] OP_CAL = 6'b100100;
  localparam logic [5:0] OP_RET = 6'b100101;
  localparam logic [5:0] OP_HLT = 6'b111111;

  typedef enum logic [1:0] {IDLE, REQ, FLUSH, HALT} fetch_state_t;

  function automatic logic is_hlt(input logic [INSN_W-1:0] ir);
    return ir[INSN_W-1 -: 6] == OP_HLT;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry {pc, ir} FIFO with synchronous clear; the head is read combinationally.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         push,
  input  logic [ADDR_W-1:0]            push_pc,
  input  logic [INSN_W-1:0]            push_ir,
  input  logic                         pop,
  output logic [ADDR_W-1:0]            head_pc,
  output logic [INSN_W-1:0]            head_ir,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] pc_mem [DEPTH];
  logic [INSN_W-1:0] ir_mem [DEPTH];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr] <= push_pc;
      ir_mem[wr_ptr] <= push_ir;
    end
  end

  assign head_pc = pc_mem[rd_ptr];
  assign head_ir = ir_mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch unit: single-outstanding req/ack fetch into a {pc, ir} queue feeding decode.
// Define FETCH_HLT_STOP_EN to stop fetching after an HLT word has been queued.
module fetch_prefetch_queue
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INSN_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [INSN_W-1:0] id_ir,
  output logic [ADDR_W-1:0] id_pc,
  output logic              halted
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_t      state, state_next;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_next, addr_q;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] head_pc;
  logic [INSN_W-1:0] head_ir;
  logic              push, pop;
  int                cnt_after_pop, cnt_after_push;

  assign pop      = id_valid & id_ready;
  assign id_valid = (count != '0);
  assign id_ir    = id_valid ? head_ir : '0;
  assign id_pc    = id_valid ? head_pc : '0;
  assign imem_addr = addr_q;

  fetch_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear   (redirect_valid),
    .push    (push),
    .push_pc (fetch_pc),
    .push_ir (imem_rdata),
    .pop     (pop),
    .head_pc (head_pc),
    .head_ir (head_ir),
    .count   (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // While a stale request is outstanding the bus address stays put; fetch_pc holds the pending target.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      addr_q   <= RESET_PC;
    end else begin
      fetch_pc <= fetch_pc_next;
      if (state_next != FLUSH) addr_q <= fetch_pc_next;
    end
  end

  always_comb begin
    state_next     = state;
    fetch_pc_next  = fetch_pc;
    push           = 1'b0;
    cnt_after_pop  = int'(count) - int'(pop);
    cnt_after_push = int'(count) + 1 - int'(pop);
    case (state)
      IDLE: begin
        if (redirect_valid) begin
          fetch_pc_next = redirect_pc;
          state_next    = REQ;
        end else if (cnt_after_pop < DEPTH) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          fetch_pc_next = redirect_pc;
          state_next    = imem_ack ? REQ : FLUSH;
        end else if (imem_ack) begin
          push          = 1'b1;
          fetch_pc_next = fetch_pc + ADDR_W'(1);
          if (cnt_after_push >= DEPTH) state_next = IDLE;
`ifdef FETCH_HLT_STOP_EN
          if (is_hlt(imem_rdata)) state_next = HALT;
`endif
        end
      end
      FLUSH: begin
        if (redirect_valid) fetch_pc_next = redirect_pc;
        if (imem_ack)       state_next    = REQ;
      end
`ifdef FETCH_HLT_STOP_EN
      HALT: begin
        if (redirect_valid) begin
          fetch_pc_next = redirect_pc;
          state_next    = REQ;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    halted   = 1'b0;
    case (state)
      REQ, FLUSH: imem_req = 1'b1;
`ifdef FETCH_HLT_STOP_EN
      HALT:       halted   = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue with a small instruction-memory model.
module tb_fetch_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_ir;
  logic [31:0] id_pc;
  logic        halted;

  logic        ack_en;
  logic        hlt_mode;
  int          checks = 0;
  int          errors = 0;
  int          acks   = 0;
  int          a0;

  always #5 clk = ~clk;

  fetch_prefetch_queue #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_ir          (id_ir),
    .id_pc          (id_pc),
    .halted         (halted)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return {8'hC0, a[23:0]};
  endfunction

  // Zero-wait memory when ack_en is set; word 5 becomes HLT in hlt_mode.
  assign imem_ack   = ack_en & imem_req;
  assign imem_rdata = (hlt_mode && imem_addr == 32'd5) ? 32'hFC00_0000 : word(imem_addr);

  always @(negedge clk) if (imem_req && imem_ack) acks++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; id_ready = 1'b1; ack_en = 1'b1; hlt_mode = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_ir", id_ir, 32'd0);
    chk("rst_pc", id_pc, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    step();
    reset = 1'b1;

    // Sequential streaming from reset.
    step();
    chk("start_req", {31'd0, imem_req}, 32'd1);
    chk("start_addr", imem_addr, 32'd0);
    chk("start_valid", {31'd0, id_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("stream_valid", {31'd0, id_valid}, 32'd1);
      chk("stream_pc", id_pc, 32'(k));
      chk("stream_ir", id_ir, word(32'(k)));
      chk("stream_addr", imem_addr, 32'(k + 1));
    end

    // Back-pressure: fill exactly DEPTH entries from a fresh start at 0x100.
    id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    chk("bp_valid", {31'd0, id_valid}, 32'd0);
    chk("bp_addr", imem_addr, 32'h100);
    a0 = acks;
    for (int k = 0; k < 7; k++) step();
    chk("bp_req_off", {31'd0, imem_req}, 32'd0);
    chk("bp_acks", 32'(acks - a0), 32'd4);
    chk("bp_head", id_pc, 32'h100);
    id_ready = 1'b1;
    step();
    chk("drain_pc1", id_pc, 32'h101);
    chk("drain_req", {31'd0, imem_req}, 32'd1);
    chk("drain_addr", imem_addr, 32'h104);
    step(); step(); step();
    chk("drain_pc4", id_pc, 32'h104);
    chk("drain_ir4", id_ir, word(32'h104));

    // Redirect while the memory withholds ack.
    ack_en = 1'b0; id_ready = 1'b0;
    step();
    chk("stall_addr", imem_addr, 32'h107);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    chk("flush_valid", {31'd0, id_valid}, 32'd0);
    chk("flush_req", {31'd0, imem_req}, 32'd1);
    chk("flush_addr_a", imem_addr, 32'h107);
    step(); step();
    chk("flush_addr_b", imem_addr, 32'h107);
    ack_en = 1'b1; id_ready = 1'b1;
    step();
    chk("flush_new_addr", imem_addr, 32'h40);
    chk("flush_drop", {31'd0, id_valid}, 32'd0);
    step();
    chk("flush_first_pc", id_pc, 32'h40);
    chk("flush_first_ir", id_ir, word(32'h40));

    // Redirect coincident with ack and a pop.
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    step();
    redirect_valid = 1'b0;
    chk("coin_valid", {31'd0, id_valid}, 32'd0);
    chk("coin_pc_zero", id_pc, 32'd0);
    chk("coin_ir_zero", id_ir, 32'd0);
    chk("coin_addr", imem_addr, 32'h10);
    step();
    chk("coin_first_pc", id_pc, 32'h10);

    // Address wrap at all-ones.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFF);
    step();
    chk("wrap_pc_top", id_pc, 32'hFFFF_FFFF);
    chk("wrap_addr_zero", imem_addr, 32'd0);
    step();
    chk("wrap_pc_zero", id_pc, 32'd0);
    chk("wrap_addr_one", imem_addr, 32'd1);

    // HLT word at PC 5.
    hlt_mode = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd3;
    step();
    redirect_valid = 1'b0;
    step(); step(); step();
    chk("hlt_pc", id_pc, 32'd5);
    chk("hlt_ir", id_ir, 32'hFC00_0000);
`ifdef FETCH_HLT_STOP_EN
    chk("hlt_halted", {31'd0, halted}, 32'd1);
    chk("hlt_req_off", {31'd0, imem_req}, 32'd0);
    step();
    chk("hlt_empty", {31'd0, id_valid}, 32'd0);
    chk("hlt_still_off", {31'd0, imem_req}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'd0;
    step();
    redirect_valid = 1'b0;
    chk("hlt_cleared", {31'd0, halted}, 32'd0);
    chk("hlt_restart_req", {31'd0, imem_req}, 32'd1);
    chk("hlt_restart_addr", imem_addr, 32'd0);
    step();
    chk("hlt_restart_pc", id_pc, 32'd0);
`else
    chk("hlt_not_halted", {31'd0, halted}, 32'd0);
    chk("hlt_req_on", {31'd0, imem_req}, 32'd1);
    chk("hlt_next_addr", imem_addr, 32'd6);
    step();
    chk("hlt_next_pc", id_pc, 32'd6);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
